// File: rtl/siso_pkg.sv
// Shared types and sizing for the SISO decoder input frame buffer.
package siso_pkg;

  localparam int DATA_W     = 16;
  localparam int MAX_BLKLEN = 6144;
  localparam int MIN_BLKLEN = 40;
  localparam int TAIL_STEPS = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL,
    READ
  } bank_state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] sys;
    logic signed [DATA_W-1:0] par;
    logic signed [DATA_W-1:0] apr;
  } step_t;

endpackage

// File: rtl/siso_step_ram.sv
// Simple dual-port step store: one write port, one registered read port.
// The read register clears on reset so replay outputs are 0 out of reset.
module siso_step_ram import siso_pkg::*; #(
  parameter int DEPTH = MAX_BLKLEN + TAIL_STEPS,
  parameter int WIDTH = $bits(step_t),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write one trellis step word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // One-cycle registered read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/siso_frame_buffer.sv
// Frame store in front of the SISO decoder: captures one trellis frame
// (K data steps + tail) and replays it forward or reverse until released.
// Build option SISO_PINGPONG_EN: two banks in FIFO order instead of one.
//
// state | meaning
// IDLE  | bank free, a frame may be opened
// LOAD  | sys/parity pairs being written, step 0..K+2
// FULL  | complete frame held, waiting for a pass or a release
// READ  | replay pass running (address issue plus output drain)
module siso_frame_buffer #(
  parameter int DATA_W     = siso_pkg::DATA_W,
  parameter int MAX_BLKLEN = siso_pkg::MAX_BLKLEN,
  parameter int MIN_BLKLEN = siso_pkg::MIN_BLKLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       blklen,
  input  logic              valid_blklen,
  input  logic [DATA_W-1:0] in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] apriori,
  input  logic              valid_apriori,
  output logic              ready,
  input  logic              rd_start,
  input  logic              rd_dir,
  input  logic              rd_release,
  output logic              frame_rdy,
  output logic [DATA_W-1:0] out_sys,
  output logic [DATA_W-1:0] out_par,
  output logic [DATA_W-1:0] out_apriori,
  output logic              out_valid,
  output logic              out_last,
  output logic              err
);
  import siso_pkg::*;

`ifdef SISO_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int DEPTH = MAX_BLKLEN + TAIL_STEPS;
  localparam int SW    = $clog2(DEPTH);
  localparam int WW    = 3 * DATA_W;

  bank_state_e       state_q   [NBANK];
  bank_state_e       state_nxt [NBANK];
  logic [SW-1:0]     k_q       [NBANK];
  logic [WW-1:0]     rdata     [NBANK];

  logic              ld_ptr, rd_ptr;
  logic [SW-1:0]     wr_step;
  logic              phase;
  logic [DATA_W-1:0] sys_hold;
  logic [SW-1:0]     rd_addr;
  logic              rd_issue, rd_dir_q;
  logic              out_valid_q, out_last_q, err_q, rst_done_q;

  logic              blk_ok, open_frame, ld_active, wr_par, wr_data_step, load_done;
  logic              start_ok, release_ok, at_end, err_nxt;
  logic [SW-1:0]     ld_last, rd_last;
  logic [DATA_W-1:0] apr_w;

  // Protocol decode for the load side (bank ld_ptr) and read side (bank rd_ptr).
  always_comb begin
    blk_ok       = (32'(blklen) >= MIN_BLKLEN) && (32'(blklen) <= MAX_BLKLEN);
    open_frame   = valid_blklen && blk_ok && (state_q[ld_ptr] == IDLE);
    ld_active    = (state_q[ld_ptr] == LOAD);
    ld_last      = k_q[ld_ptr] + SW'(TAIL_STEPS - 1);
    wr_par       = valid_in && ld_active && phase;
    wr_data_step = (wr_step < k_q[ld_ptr]);
    load_done    = wr_par && (wr_step == ld_last);
    apr_w        = (wr_data_step && valid_apriori) ? apriori : '0;
    release_ok   = rd_release && (state_q[rd_ptr] == FULL);
    start_ok     = rd_start && !rd_release && (state_q[rd_ptr] == FULL);
    rd_last      = k_q[rd_ptr] + SW'(TAIL_STEPS - 1);
    at_end       = rd_dir_q ? (rd_addr == '0) : (rd_addr == rd_last);
    err_nxt      = (valid_blklen && (!blk_ok || (state_q[ld_ptr] != IDLE)))
                || (valid_in && !ld_active)
                || (rd_start && !rd_release && (state_q[rd_ptr] != FULL))
                || (wr_par && wr_data_step && !valid_apriori);
  end

  // Per-bank next state. READ holds until the final step has left the
  // output register, so frame_rdy returns the cycle after out_last.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      state_nxt[b] = state_q[b];
      unique case (state_q[b])
        IDLE: if (open_frame && int'(ld_ptr) == b) state_nxt[b] = LOAD;
        LOAD: if (load_done && int'(ld_ptr) == b)  state_nxt[b] = FULL;
        FULL: if (int'(rd_ptr) == b) begin
                if (release_ok)    state_nxt[b] = IDLE;
                else if (start_ok) state_nxt[b] = READ;
              end
        READ: if (out_last_q && int'(rd_ptr) == b) state_nxt[b] = FULL;
      endcase
    end
  end

  // Bank state register and latched block length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) begin
        state_q[b] <= IDLE;
        k_q[b]     <= '0;
      end
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        state_q[b] <= state_nxt[b];
        if (open_frame && int'(ld_ptr) == b) k_q[b] <= SW'(blklen);
      end
    end
  end

  // Load side: sys held until its parity arrives, then the step word is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ptr   <= 1'b0;
      wr_step  <= '0;
      phase    <= 1'b0;
      sys_hold <= '0;
    end else if (open_frame) begin
      wr_step <= '0;
      phase   <= 1'b0;
    end else if (valid_in && ld_active) begin
      phase <= ~phase;
      if (!phase) begin
        sys_hold <= in;
      end else if (load_done) begin
        wr_step <= '0;
        ld_ptr  <= (NBANK == 2) ? ~ld_ptr : 1'b0;
      end else begin
        wr_step <= wr_step + SW'(1);
      end
    end
  end

  // Read side: address counter up or down, output valid/last one cycle behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= 1'b0;
      rd_addr     <= '0;
      rd_issue    <= 1'b0;
      rd_dir_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= rd_issue;
      out_last_q  <= rd_issue && at_end;
      if (start_ok) begin
        rd_issue <= 1'b1;
        rd_dir_q <= rd_dir;
        rd_addr  <= rd_dir ? rd_last : '0;
      end else if (rd_issue) begin
        if (at_end)        rd_issue <= 1'b0;
        else if (rd_dir_q) rd_addr  <= rd_addr - SW'(1);
        else               rd_addr  <= rd_addr + SW'(1);
      end
      if (release_ok) rd_ptr <= (NBANK == 2) ? ~rd_ptr : 1'b0;
    end
  end

  // Error pulse and post-reset enable for ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      err_q      <= err_nxt;
      rst_done_q <= 1'b1;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    siso_step_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WW),
      .AW    (SW)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_par && int'(ld_ptr) == b),
      .waddr (wr_step),
      .wdata ({sys_hold, in, apr_w}),
      .re    (rd_issue && int'(rd_ptr) == b),
      .raddr (rd_addr),
      .rdata (rdata[b])
    );
  end

  assign {out_sys, out_par, out_apriori} = rdata[rd_ptr];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign frame_rdy = (state_q[rd_ptr] == FULL);
  assign ready     = rst_done_q && ((state_q[ld_ptr] == IDLE) || (state_q[ld_ptr] == LOAD));

endmodule

// File: tb/tb_siso_frame_buffer.sv
// Directed bench for siso_frame_buffer; the ping-pong scenario is built
// only when SISO_PINGPONG_EN is defined.
module tb_siso_frame_buffer;

`ifdef SISO_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] blklen = '0;
  logic        valid_blklen = 1'b0;
  logic [15:0] in_s = '0;
  logic        valid_in = 1'b0;
  logic [15:0] apriori = '0;
  logic        valid_apriori = 1'b0;
  logic        ready;
  logic        rd_start = 1'b0;
  logic        rd_dir = 1'b0;
  logic        rd_release = 1'b0;
  logic        frame_rdy;
  logic [15:0] out_sys, out_par, out_apriori;
  logic        out_valid, out_last, err;

  int n_checks = 0;
  int n_fail   = 0;

  // results of the load helper
  int   ld_err_cnt;
  logic ld_rdy_before;

  // results of the pass capture helper
  logic [15:0] cap_sys [7000];
  logic [15:0] cap_par [7000];
  logic [15:0] cap_apr [7000];
  int   cap_n, cap_lat, cap_lastcnt, cap_last_idx;
  logic cap_timeout, cap_rdy_at_last, cap_rdy_after, cap_poke_err, cap_err_seen;

  siso_frame_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .blklen        (blklen),
    .valid_blklen  (valid_blklen),
    .in            (in_s),
    .valid_in      (valid_in),
    .apriori       (apriori),
    .valid_apriori (valid_apriori),
    .ready         (ready),
    .rd_start      (rd_start),
    .rd_dir        (rd_dir),
    .rd_release    (rd_release),
    .frame_rdy     (frame_rdy),
    .out_sys       (out_sys),
    .out_par       (out_par),
    .out_apriori   (out_apriori),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame content per mode: 0 plain, 1 big (value = sample index),
  // 2 like 0 but step 5 sent without a-priori, 3 second ping-pong frame.
  function automatic int e_sys(input int mode, input int n);
    case (mode)
      1:       return 2 * n;
      3:       return 500 + n;
      default: return n;
    endcase
  endfunction

  function automatic int e_par(input int mode, input int n);
    case (mode)
      1:       return 2 * n + 1;
      3:       return 1500 + n;
      default: return 1000 + n;
    endcase
  endfunction

  function automatic int e_apr(input int mode, input int k, input int n);
    if (n >= k) return 0;
    if (mode == 1) return n;
    if (mode == 2 && n == 5) return 0;
    return -n;
  endfunction

  function automatic int count_bad(input int mode, input int k, input logic dir);
    int bad = 0;
    for (int j = 0; j < cap_n; j++) begin
      int n;
      n = dir ? (k + 2 - j) : j;
      if (cap_sys[j] !== 16'(e_sys(mode, n)) || cap_par[j] !== 16'(e_par(mode, n)) ||
          cap_apr[j] !== 16'(e_apr(mode, k, n))) bad++;
    end
    return bad;
  endfunction

  task automatic load_frame(input int k, input int mode);
    int errs = 0;
    blklen = 16'(k);
    valid_blklen = 1'b1;
    tick();
    valid_blklen = 1'b0;
    if (err) errs++;
    for (int n = 0; n < k + 3; n++) begin
      for (int ph = 0; ph < 2; ph++) begin
        valid_in = 1'b1;
        in_s = (ph == 0) ? 16'(e_sys(mode, n)) : 16'(e_par(mode, n));
        if (ph == 1) begin
          if (n < k) begin
            apriori       = (mode == 1) ? 16'(n) : 16'(-n);
            valid_apriori = !(mode == 2 && n == 5);
          end else begin
            apriori       = 16'(77);
            valid_apriori = 1'b1;
          end
        end
        if (n == k + 2 && ph == 1) ld_rdy_before = frame_rdy;
        tick();
        if (err) errs++;
        valid_apriori = 1'b0;
      end
    end
    valid_in = 1'b0;
    ld_err_cnt = errs;
  endtask

  task automatic run_pass(input logic dir, input int poke);
    int lat;
    cap_n = 0; cap_lastcnt = 0; cap_last_idx = -1; cap_timeout = 1'b0;
    cap_poke_err = 1'b0; cap_rdy_at_last = 1'b0; cap_err_seen = 1'b0;
    rd_dir = dir;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    cap_lat = lat;
    if (!out_valid) begin
      cap_timeout = 1'b1;
      return;
    end
    while (out_valid && cap_n < 7000) begin
      cap_sys[cap_n] = out_sys;
      cap_par[cap_n] = out_par;
      cap_apr[cap_n] = out_apriori;
      if (out_last) begin
        cap_lastcnt++;
        cap_last_idx = cap_n;
        cap_rdy_at_last = frame_rdy;
      end
      cap_n++;
      if (cap_n == poke) rd_start = 1'b1;
      tick();
      if (cap_n == poke) begin
        rd_start = 1'b0;
        cap_poke_err = err;
      end else if (err) begin
        cap_err_seen = 1'b1;
      end
    end
    cap_rdy_after = frame_rdy;
  endtask

  task automatic release_frame();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_checks++; if (frame_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_frame_rdy got %b want 0", frame_rdy); end
    n_checks++; if ({out_valid, out_last, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {out_valid, out_last, err}); end
    n_checks++; if ({out_sys, out_par, out_apriori} !== 48'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {out_sys, out_par, out_apriori}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", ready); end
  endtask

  task automatic test_forward();
    load_frame(40, 0);
    n_checks++; if (ld_rdy_before !== 1'b0) begin n_fail++; $display("FAIL fwd_rdy_early got %b want 0", ld_rdy_before); end
    n_checks++; if (frame_rdy !== 1'b1) begin n_fail++; $display("FAIL fwd_frame_rdy got %b want 1", frame_rdy); end
    n_checks++; if (ready !== PP) begin n_fail++; $display("FAIL fwd_ready_full got %b want %b", ready, PP); end
    n_checks++; if (ld_err_cnt !== 0) begin n_fail++; $display("FAIL fwd_load_err got %0d want 0", ld_err_cnt); end
    run_pass(1'b0, -1);
    n_checks++; if (cap_lat !== 2) begin n_fail++; $display("FAIL fwd_latency got %0d want 2", cap_lat); end
    n_checks++; if (cap_n !== 43) begin n_fail++; $display("FAIL fwd_steps got %0d want 43", cap_n); end
    n_checks++; if (cap_lastcnt !== 1 || cap_last_idx !== 42) begin n_fail++; $display("FAIL fwd_last got cnt=%0d idx=%0d want 1/42", cap_lastcnt, cap_last_idx); end
    n_checks++; if (count_bad(0, 40, 1'b0) !== 0) begin n_fail++; $display("FAIL fwd_data got %0d bad steps want 0", count_bad(0, 40, 1'b0)); end
    n_checks++; if (cap_rdy_at_last !== 1'b0 || cap_rdy_after !== 1'b1) begin n_fail++; $display("FAIL fwd_rdy_return got last=%b after=%b want 0/1", cap_rdy_at_last, cap_rdy_after); end
  endtask

  task automatic test_back_to_back();
    run_pass(1'b1, -1);
    n_checks++; if (cap_sys[0] !== 16'd42 || cap_par[0] !== 16'd1042 || cap_apr[0] !== 16'd0) begin n_fail++; $display("FAIL rev_first got %0d/%0d/%0d want 42/1042/0", cap_sys[0], cap_par[0], cap_apr[0]); end
    n_checks++; if (cap_n !== 43 || cap_last_idx !== 42) begin n_fail++; $display("FAIL rev_steps got n=%0d last=%0d want 43/42", cap_n, cap_last_idx); end
    n_checks++; if (count_bad(0, 40, 1'b1) !== 0) begin n_fail++; $display("FAIL rev_data got %0d bad steps want 0", count_bad(0, 40, 1'b1)); end
    run_pass(1'b0, -1);
    n_checks++; if (cap_lat !== 2 || cap_n !== 43) begin n_fail++; $display("FAIL b2b_fwd got lat=%0d n=%0d want 2/43", cap_lat, cap_n); end
    n_checks++; if (count_bad(0, 40, 1'b0) !== 0) begin n_fail++; $display("FAIL b2b_fwd_data got %0d bad steps want 0", count_bad(0, 40, 1'b0)); end
    n_checks++; if (cap_err_seen !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b want 0", cap_err_seen); end
  endtask

  task automatic test_bad_blklen();
    int seen;
    release_frame();
    n_checks++; if (ready !== 1'b1 || frame_rdy !== 1'b0) begin n_fail++; $display("FAIL rel_state got ready=%b frame_rdy=%b want 1/0", ready, frame_rdy); end
    blklen = 16'd39; valid_blklen = 1'b1; tick(); valid_blklen = 1'b0;
    n_checks++; if (err !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL k39 got err=%b ready=%b want 1/1", err, ready); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse got %b want 0", err); end
    blklen = 16'd6145; valid_blklen = 1'b1; tick(); valid_blklen = 1'b0;
    n_checks++; if (err !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL k6145 got err=%b ready=%b want 1/1", err, ready); end
    valid_in = 1'b1; tick(); valid_in = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL idle_valid_in got err=%b want 1", err); end
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL idle_rd_start got err=%b want 1", err); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL idle_no_output got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_start_release();
    int seen;
    load_frame(40, 0);
    rd_start = 1'b1; rd_release = 1'b1; tick(); rd_start = 1'b0; rd_release = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sr_err got %b want 0", err); end
    n_checks++; if (frame_rdy !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL sr_state got frame_rdy=%b ready=%b want 0/1", frame_rdy, ready); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL sr_no_output got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_missing_apriori();
    load_frame(40, 2);
    n_checks++; if (ld_err_cnt !== 1) begin n_fail++; $display("FAIL apr_missing_err got %0d pulses want 1", ld_err_cnt); end
    run_pass(1'b0, 10);
    n_checks++; if (cap_poke_err !== 1'b1) begin n_fail++; $display("FAIL start_in_read got err=%b want 1", cap_poke_err); end
    n_checks++; if (cap_n !== 43 || cap_last_idx !== 42) begin n_fail++; $display("FAIL start_in_read_len got n=%0d last=%0d want 43/42", cap_n, cap_last_idx); end
    n_checks++; if (count_bad(2, 40, 1'b0) !== 0) begin n_fail++; $display("FAIL apr_missing_data got %0d bad steps want 0", count_bad(2, 40, 1'b0)); end
    release_frame();
  endtask

  task automatic test_max_blklen();
    load_frame(6144, 1);
    n_checks++; if (frame_rdy !== 1'b1 || ld_err_cnt !== 0) begin n_fail++; $display("FAIL big_load got frame_rdy=%b errs=%0d want 1/0", frame_rdy, ld_err_cnt); end
    run_pass(1'b0, -1);
    n_checks++; if (cap_n !== 6147 || cap_last_idx !== 6146) begin n_fail++; $display("FAIL big_fwd_len got n=%0d last=%0d want 6147/6146", cap_n, cap_last_idx); end
    n_checks++; if (cap_sys[6146] !== 16'd12292 || cap_par[6146] !== 16'd12293) begin n_fail++; $display("FAIL big_top_step got %0d/%0d want 12292/12293", cap_sys[6146], cap_par[6146]); end
    n_checks++; if (cap_apr[6143] !== 16'd6143 || cap_apr[6144] !== 16'd0) begin n_fail++; $display("FAIL big_apr_edge got %0d/%0d want 6143/0", cap_apr[6143], cap_apr[6144]); end
    n_checks++; if (count_bad(1, 6144, 1'b0) !== 0) begin n_fail++; $display("FAIL big_fwd_data got %0d bad steps want 0", count_bad(1, 6144, 1'b0)); end
    run_pass(1'b1, -1);
    n_checks++; if (cap_n !== 6147 || cap_sys[0] !== 16'd12292 || cap_sys[6146] !== 16'd0) begin n_fail++; $display("FAIL big_rev got n=%0d first=%0d last=%0d want 6147/12292/0", cap_n, cap_sys[0], cap_sys[6146]); end
    release_frame();
  endtask

  task automatic test_reset_mid_read();
    load_frame(40, 0);
    rd_dir = 1'b0; rd_start = 1'b1; tick(); rd_start = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_read_active got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if ({out_valid, out_last, err, ready, frame_rdy} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_flags got %b want 00000", {out_valid, out_last, err, ready, frame_rdy}); end
    n_checks++; if ({out_sys, out_par, out_apriori} !== 48'h0) begin n_fail++; $display("FAIL mid_reset_data got %h want 0", {out_sys, out_par, out_apriori}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++; if (ready !== 1'b1 || frame_rdy !== 1'b0) begin n_fail++; $display("FAIL after_reset got ready=%b frame_rdy=%b want 1/0", ready, frame_rdy); end
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL discarded_start got err=%b want 1", err); end
  endtask

`ifdef SISO_PINGPONG_EN
  task automatic test_pingpong();
    int bad_a;
    load_frame(40, 0);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_one got %b want 1", ready); end
    fork
      load_frame(40, 3);
      run_pass(1'b0, -1);
    join
    bad_a = count_bad(0, 40, 1'b0);
    n_checks++; if (cap_n !== 43 || bad_a !== 0) begin n_fail++; $display("FAIL pp_pass_a got n=%0d bad=%0d want 43/0", cap_n, bad_a); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL pp_ready_both got %b want 0", ready); end
    release_frame();
    n_checks++; if (ready !== 1'b1 || frame_rdy !== 1'b1) begin n_fail++; $display("FAIL pp_after_rel got ready=%b frame_rdy=%b want 1/1", ready, frame_rdy); end
    run_pass(1'b0, -1);
    n_checks++; if (cap_n !== 43 || count_bad(3, 40, 1'b0) !== 0) begin n_fail++; $display("FAIL pp_pass_b got n=%0d bad=%0d want 43/0", cap_n, count_bad(3, 40, 1'b0)); end
    release_frame();
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_bad_blklen();
    test_start_release();
    test_missing_apriori();
    test_max_blklen();
    test_reset_mid_read();
`ifdef SISO_PINGPONG_EN
    test_pingpong();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
